sqrt_unit: RTL and testbench

Fixed-point square-root stage directly downstream of the divider. It consumes the divider's 20-bit quotient (11 fractional bits) on a valid strobe. It computes the root with a one-bit-per-cycle restoring digit-recurrence and returns a 16-bit root that keeps the same 11-bit fractional scaling. Latency is fixed, there is no backpressure, and a busy flag tells upstream when a new operand would be dropped.

---
 rtl/sqrt_unit_if.sv | 21 ++
 rtl/sqrt_unit.sv | 109 ++++++++++
 tb/tb_sqrt_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sqrt_unit_if.sv
// Operand/result bundle between the divider output and the square-root stage.
interface sqrt_unit_if #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, busy
  );
endinterface

// File: rtl/sqrt_unit.sv
// Fixed-point restoring square root, one root bit per cycle, no backpressure (busy drops operands).
// Latency 17 cycles from acceptance; SQRT_ROUND_EN selects round-to-nearest with one extra cycle.
module sqrt_unit #(
  parameter int IN_W   = 20,
  parameter int FRAC_W = 11
) (
  input  logic        clk,
  input  logic        rst,
  sqrt_unit_if.slave  bus
);
  localparam int OUT_W = (IN_W + FRAC_W + 1) / 2;
`ifdef SQRT_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  // One extra root bit (two extra radicand bits) carries the rounding information.
  localparam int ROOT_W = OUT_W + RND;
  localparam int RAD_W  = 2 * ROOT_W;
  localparam int REM_W  = ROOT_W + 2;
  localparam int CNT_W  = $clog2(ROOT_W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             r_state;
  logic               r_armed;
  logic [RAD_W-1:0]   r_rad;
  logic [REM_W-1:0]   r_rem;
  logic [ROOT_W-1:0]  r_root;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_data;
  logic               r_busy;

  logic [REM_W-1:0]   w_rem_sh;
  logic [REM_W-1:0]   w_trial;
  logic               w_ge;
  logic [REM_W-1:0]   w_rem_nxt;
  logic [ROOT_W-1:0]  w_root_nxt;
  logic [OUT_W-1:0]   w_result;

  // Remainder headroom is bounded by 2*root+1, so the bits shifted out are always zero.
  assign w_rem_sh   = REM_W'({r_rem, r_rad[RAD_W-1 -: 2]});
  assign w_trial    = {r_root, 2'b01};
  assign w_ge       = (w_rem_sh >= w_trial);
  assign w_rem_nxt  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
  assign w_root_nxt = ROOT_W'({r_root, w_ge});

`ifdef SQRT_ROUND_EN
  assign w_result = OUT_W'((w_root_nxt + ROOT_W'(1)) >> 1);
`else
  assign w_result = w_root_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_armed     <= 1'b1;
      r_rad       <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (!bus.in_valid) r_armed <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_armed) begin
            r_armed <= 1'b0;
            r_rad   <= RAD_W'(bus.in_data) << (FRAC_W + 2 * RND);
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= CNT_W'(ROOT_W - 1);
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end

        S_CALC: begin
          r_rad  <= {r_rad[RAD_W-3:0], 2'b00};
          r_rem  <= w_rem_nxt;
          r_root <= w_root_nxt;
          r_cnt  <= r_cnt - CNT_W'(1);
          // Result registers load with the final iteration so out_valid coincides with DONE.
          if (r_cnt == '0) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_sqrt_unit.sv
// Scoreboard bench for sqrt_unit: randomized and directed operands against an integer-sqrt model.
module tb_sqrt_unit;
  localparam int IN_W  = 20;
  localparam int OUT_W = 16;
`ifdef SQRT_ROUND_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  typedef struct {
    logic [OUT_W-1:0] data;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   errors = 0;
  exp_t sb_q[$];

  sqrt_unit_if #(.IN_W(IN_W), .OUT_W(OUT_W)) sif ();

  sqrt_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint isqrt(input longint v);
    longint lo = 0;
    longint hi = 64'd1 << 20;
    while (lo < hi) begin
      longint mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic logic [OUT_W-1:0] ref_sqrt(input logic [IN_W-1:0] x);
    longint v = longint'(x);
`ifdef SQRT_ROUND_EN
    return OUT_W'((isqrt(v << 13) + 1) >> 1);
`else
    return OUT_W'(isqrt(v << 11));
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called at a falling edge; returns at the first falling edge with busy low.
  task automatic wait_idle();
    int n = 0;
    while (sif.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sif.busy) check("idle_timeout", 1, 0);
  endtask

  task automatic send(input logic [IN_W-1:0] x, input int hold, input bit expect_out);
    exp_t e;
    wait_idle();
    sif.in_valid = 1'b1;
    sif.in_data  = x;
    if (expect_out) begin
      e.data = ref_sqrt(x);
      e.cyc  = cyc + LAT;
      sb_q.push_back(e);
    end
    repeat (hold) @(negedge clk);
    sif.in_valid = 1'b0;
  endtask

  // Monitor: every out_valid must match the oldest outstanding expectation, in value and timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sif.out_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("out_data", sif.out_data, e.data);
          check("latency_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [IN_W-1:0] x;
    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", sif.out_valid, 0);
    check("rst_out_data", sif.out_data, 0);
    check("rst_busy", sif.busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1.0 strobed for one cycle; busy must span exactly the latency window.
    send(20'h00800, 1, 1'b1);
    nb = 0;
    while (sif.busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    check("busy_width", nb, LAT);

    send(20'h02000, 1, 1'b1);
    send(20'h01000, 1, 1'b1);
    send(20'h00000, 1, 1'b1);
    send(20'hFFFFF, 1, 1'b1);
    send(20'h00003, 1, 1'b1);
    wait_idle();
    repeat (5) @(negedge clk);
    check("out_data_hold", sif.out_data, ref_sqrt(20'h00003));

    // Held strobe accepted once; a strobe arriving mid-calculation is dropped.
    send(20'h00800, 3, 1'b1);
    repeat (4) @(negedge clk);
    sif.in_valid = 1'b1;
    sif.in_data  = 20'h01234;
    @(negedge clk);
    sif.in_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("ignored_strobe_out_data", sif.out_data, ref_sqrt(20'h00800));
    send(20'h01234, 1, 1'b1);

    // Reset in the middle of the recurrence kills the result.
    send(20'h05A5A, 1, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", sif.out_valid, 0);
    check("midrst_out_data", sif.out_data, 0);
    check("midrst_busy", sif.busy, 0);
    @(negedge clk);
    send(20'h00C00, 1, 1'b1);

    for (int i = 0; i < 30; i++) begin
      case (i % 8)
        0:       x = 20'hFFFFF;
        4:       x = 20'h00001;
        default: x = IN_W'($urandom);
      endcase
      send(x, $urandom_range(1, 3), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_idle();
    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
